// File: rtl/ifm_fetch_controller_pkg.sv
// Shared types and constants for the IFM fetch path that drains the
// inter-layer RAM into wide IFM beats.
package ifm_fetch_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        HOLD,
        DONE
    } fetch_state_e;

    localparam int WORDS_PER_BEAT_DEF = 4;
    localparam int RD_LATENCY         = 1;

    function automatic int slot_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ifm_beat_assembler.sv
// Capture register that scatters consecutive RAM words into the slots of
// one wide IFM beat; slot k lands in bits [k*DATA_W +: DATA_W].
module ifm_beat_assembler
    import ifm_fetch_controller_pkg::*;
#(
    parameter  int DATA_W         = 32,
    parameter  int WORDS_PER_BEAT = WORDS_PER_BEAT_DEF,
    localparam int SLOT_W         = slot_width(WORDS_PER_BEAT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cap_en,
    input  logic [SLOT_W-1:0]                cap_slot,
    input  logic [DATA_W-1:0]                cap_data,
    output logic [WORDS_PER_BEAT*DATA_W-1:0] beat
);

    for (genvar k = 0; k < WORDS_PER_BEAT; k++) begin : g_slot
        logic [DATA_W-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (cap_en && (cap_slot == SLOT_W'(k))) begin
                word_q <= cap_data;
            end
        end

        assign beat[k*DATA_W +: DATA_W] = word_q;
    end

endmodule

// File: rtl/ifm_fetch_controller.sv
// Reads full four-word groups behind the OFM writer's live pointer and hands
// each group downstream as one IFM beat with valid/ready handshaking.
module ifm_fetch_controller
    import ifm_fetch_controller_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int WORDS_PER_BEAT = WORDS_PER_BEAT_DEF,
    parameter int CNT_W          = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    input  logic [CNT_W-1:0]                 num_beats,
    input  logic [ADDR_W-1:0]                wr_ptr,
    output logic                             rd_en,
    output logic [ADDR_W-1:0]                rd_addr,
    input  logic [DATA_W-1:0]                rd_data,
    output logic [WORDS_PER_BEAT*DATA_W-1:0] ifm_data,
    output logic                             ifm_valid,
    input  logic                             ifm_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int                SLOT_W      = slot_width(WORDS_PER_BEAT);
    localparam int                PIPE_W      = RD_LATENCY * SLOT_W;
    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(WORDS_PER_BEAT - 1);
    localparam logic [ADDR_W-1:0] GROUP_WORDS = ADDR_W'(WORDS_PER_BEAT);

    fetch_state_e state, state_nxt;

    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W-1:0]     avail;
    logic [CNT_W-1:0]      beat_cnt;
    logic [SLOT_W-1:0]     slot;
    logic                  last_slot;
    logic                  accept;
    logic                  xfer;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [PIPE_W-1:0]     slot_pipe;
    logic                  cap_en;
    logic [SLOT_W-1:0]     cap_slot;

    // Modular distance handles the writer wrapping past the top of the RAM.
    assign avail     = wr_ptr - rd_ptr;
    assign last_slot = (slot == LAST_SLOT);
    assign xfer      = ifm_valid & ifm_ready;
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign rd_addr   = rd_en ? rd_ptr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_beats == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (avail >= GROUP_WORDS) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_slot) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (xfer) begin
                    state_nxt = (beat_cnt == CNT_W'(1)) ? DONE : WAIT;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = (num_beats == '0) ? DONE : WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            beat_cnt  <= '0;
            slot      <= '0;
            ifm_valid <= 1'b0;
        end else begin
            if (accept) begin
                rd_ptr   <= base_addr;
                beat_cnt <= num_beats;
                slot     <= '0;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                slot   <= last_slot ? '0 : slot + 1'b1;
            end
            if (xfer) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
            // The beat becomes visible only once the final word has landed.
            if (cap_en && (cap_slot == LAST_SLOT)) begin
                ifm_valid <= 1'b1;
            end else if (xfer) begin
                ifm_valid <= 1'b0;
            end
        end
    end

    // Read-return alignment: slot tags travel with the strobe for RD_LATENCY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            slot_pipe <= '0;
        end else begin
            vld_pipe  <= RD_LATENCY'({vld_pipe, rd_en});
            slot_pipe <= PIPE_W'({slot_pipe, slot});
        end
    end

    assign cap_en   = vld_pipe[RD_LATENCY-1];
    assign cap_slot = slot_pipe[PIPE_W-1 -: SLOT_W];

    ifm_beat_assembler #(
        .DATA_W         (DATA_W),
        .WORDS_PER_BEAT (WORDS_PER_BEAT)
    ) u_assembler (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_en   (cap_en),
        .cap_slot (cap_slot),
        .cap_data (rd_data),
        .beat     (ifm_data)
    );

endmodule
